// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_pkg                                                            |
// | Shared constants and state encoding for the fetch redirect block.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fetch_pkg;

    localparam int PC_W         = 15;
    localparam int FETCH_STRIDE = 8;

    typedef enum logic [1:0] {
        FR_RUN        = 2'd0,
        FR_HOLD       = 2'd1,
        FR_HOLD_REDIR = 2'd2
    } fr_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_redirect_redir_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | redir_arb                                                            |
// | Lane-priority arbiter: the older lane 0 wins over lane 1.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module redir_arb #(
    parameter int PC_W = 15
) (
    input  logic            x0_valid,
    input  logic            x0_is_jump,
    input  logic            x0_br_taken,
    input  logic [PC_W-1:0] x0_t_pc,
    input  logic            x1_valid,
    input  logic            x1_is_jump,
    input  logic            x1_br_taken,
    input  logic [PC_W-1:0] x1_t_pc,
    output logic            redir,
    output logic            x0_redir,
    output logic [PC_W-1:0] tgt
);

    logic w_x1_redir;

    always_comb begin
        x0_redir   = x0_valid & (x0_is_jump | x0_br_taken);
        w_x1_redir = x1_valid & (x1_is_jump | x1_br_taken);
        redir      = x0_redir | w_x1_redir;
        tgt        = x0_redir ? x0_t_pc : x1_t_pc;
    end

endmodule
`default_nettype wire

// File: rtl/fetch_redirect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_redirect                                                       |
// | Dual-issue fetch PC generator with stall-tolerant redirect handling. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fetch_redirect #(
    parameter int              PC_W     = 15,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x0_valid,
    input  logic             x0_is_jump,
    input  logic             x0_br_taken,
    input  logic [PC_W-1:0]  x0_t_pc,
    input  logic             x1_valid,
    input  logic             x1_is_jump,
    input  logic             x1_br_taken,
    input  logic [PC_W-1:0]  x1_t_pc,
    input  logic             stall,
    output logic [PC_W-1:0]  f_pc,
    output logic             f_slot0_valid,
    output logic             f_slot1_valid,
    output logic             flush_d,
    output logic             flush_x1,
    output logic [CNT_W-1:0] redirect_cnt
);

    import fetch_pkg::*;

    fr_state_t        r_state;
    logic [PC_W-1:0]  r_f_pc;
    logic [PC_W-1:0]  r_pend_tgt;
    logic             r_slot0_valid;
    logic             r_slot1_valid;
    logic [CNT_W-1:0] r_cnt;

    logic             w_redir;
    logic             w_x0_redir;
    logic [PC_W-1:0]  w_tgt;
    logic             w_take;
    logic [PC_W-1:0]  w_apply_tgt;
    logic             w_unused_lsbs;

    redir_arb #(.PC_W(PC_W)) u_arb (
        .x0_valid    (x0_valid),
        .x0_is_jump  (x0_is_jump),
        .x0_br_taken (x0_br_taken),
        .x0_t_pc     (x0_t_pc),
        .x1_valid    (x1_valid),
        .x1_is_jump  (x1_is_jump),
        .x1_br_taken (x1_br_taken),
        .x1_t_pc     (x1_t_pc),
        .redir       (w_redir),
        .x0_redir    (w_x0_redir),
        .tgt         (w_tgt)
    );

    // A captured redirect is the oldest one, so it overrides live lane inputs.
    always_comb begin
        w_take        = (r_state == FR_HOLD_REDIR) | w_redir;
        w_apply_tgt   = (r_state == FR_HOLD_REDIR) ? r_pend_tgt : w_tgt;
        flush_d       = !stall & w_take;
        flush_x1      = !stall & w_x0_redir;
        w_unused_lsbs = ^{w_apply_tgt[1:0]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= FR_RUN;
            r_f_pc        <= RESET_PC;
            r_pend_tgt    <= '0;
            r_slot0_valid <= 1'b1;
            r_slot1_valid <= 1'b1;
            r_cnt         <= '0;
        end else if (!stall) begin
            r_state       <= FR_RUN;
            r_slot1_valid <= 1'b1;
            if (w_take) begin
                r_f_pc        <= {w_apply_tgt[PC_W-1:3], 3'b000};
                r_slot0_valid <= !w_apply_tgt[2];
                if (r_cnt != {CNT_W{1'b1}}) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_f_pc        <= r_f_pc + PC_W'(FETCH_STRIDE);
                r_slot0_valid <= 1'b1;
            end
        end else if (r_state != FR_HOLD_REDIR) begin
            if (w_redir) begin
                r_pend_tgt <= w_tgt;
                r_state    <= FR_HOLD_REDIR;
            end else begin
                r_state    <= FR_HOLD;
            end
        end
    end

    assign f_pc          = r_f_pc;
    assign f_slot0_valid = r_slot0_valid;
    assign f_slot1_valid = r_slot1_valid;
    assign redirect_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_redirect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_redirect                                                    |
// | Directed scoreboard bench for fetch_redirect.                        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_fetch_redirect;

    localparam int PC_W  = 15;
    localparam int CNT_W = 16;
    localparam logic [PC_W-1:0] RESET_PC = 15'h0000;

    logic clk = 1'b0;
    logic reset, stall;
    logic x0_valid, x0_is_jump, x0_br_taken, x1_valid, x1_is_jump, x1_br_taken;
    logic [PC_W-1:0]  x0_t_pc, x1_t_pc, f_pc;
    logic f_slot0_valid, f_slot1_valid, flush_d, flush_x1;
    logic [CNT_W-1:0] redirect_cnt;

    always #5 clk = ~clk;

    fetch_redirect #(.PC_W(PC_W), .RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .x0_valid(x0_valid), .x0_is_jump(x0_is_jump), .x0_br_taken(x0_br_taken), .x0_t_pc(x0_t_pc),
        .x1_valid(x1_valid), .x1_is_jump(x1_is_jump), .x1_br_taken(x1_br_taken), .x1_t_pc(x1_t_pc),
        .stall(stall), .f_pc(f_pc), .f_slot0_valid(f_slot0_valid), .f_slot1_valid(f_slot1_valid),
        .flush_d(flush_d), .flush_x1(flush_x1), .redirect_cnt(redirect_cnt)
    );

    typedef struct {
        string            tag;
        logic [PC_W-1:0]  pc;
        logic             s0;
        logic             s1;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Reference model, written from the behavioural description.
    logic [PC_W-1:0]  m_pc, m_pend;
    logic             m_s0, m_s1;
    logic [CNT_W-1:0] m_cnt;
    int               m_state = 0;   // 0 RUN, 1 HOLD, 2 HOLD_REDIR

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic drive(input logic rst, input logic stl,
                         input logic v0, input logic j0, input logic b0, input logic [PC_W-1:0] t0,
                         input logic v1, input logic j1, input logic b1, input logic [PC_W-1:0] t1);
        reset = rst; stall = stl;
        x0_valid = v0; x0_is_jump = j0; x0_br_taken = b0; x0_t_pc = t0;
        x1_valid = v1; x1_is_jump = j1; x1_br_taken = b1; x1_t_pc = t1;
        #1;
    endtask

    task automatic apply_tgt(input logic [PC_W-1:0] t);
        m_pc = {t[PC_W-1:3], 3'b000};
        m_s0 = !t[2];
        m_s1 = 1'b1;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    endtask

    task automatic tick(input string tag, input bit do_chk);
        logic r0, r1, rd, efd, efx;
        logic [PC_W-1:0] tg;
        exp_t e, got;
        r0  = x0_valid & (x0_is_jump | x0_br_taken);
        r1  = x1_valid & (x1_is_jump | x1_br_taken);
        rd  = r0 | r1;
        tg  = r0 ? x0_t_pc : x1_t_pc;
        efd = (!stall & rd) | (m_state == 2 & !stall);
        efx = !stall & r0;
        if (do_chk) begin
            chk({tag, ".flush_d"}, 32'(flush_d), 32'(efd));
            chk({tag, ".flush_x1"}, 32'(flush_x1), 32'(efx));
        end
        if (reset) begin
            m_pc = RESET_PC; m_s0 = 1'b1; m_s1 = 1'b1; m_cnt = '0; m_state = 0; m_pend = '0;
        end else if (m_state == 2) begin
            if (!stall) begin apply_tgt(m_pend); m_state = 0; end
        end else if (!stall) begin
            if (rd) apply_tgt(tg);
            else begin m_pc = m_pc + 15'd8; m_s0 = 1'b1; m_s1 = 1'b1; end
            m_state = 0;
        end else if (rd) begin
            m_pend = tg; m_state = 2;
        end else begin
            m_state = 1;
        end
        e.tag = tag; e.pc = m_pc; e.s0 = m_s0; e.s1 = m_s1; e.cnt = m_cnt;
        exp_q.push_back(e);
        @(posedge clk); #1;
        got = exp_q.pop_front();
        if (do_chk) begin
            chk({got.tag, ".f_pc"}, 32'(f_pc), 32'(got.pc));
            chk({got.tag, ".slot0"}, 32'(f_slot0_valid), 32'(got.s0));
            chk({got.tag, ".slot1"}, 32'(f_slot1_valid), 32'(got.s1));
            chk({got.tag, ".cnt"}, 32'(redirect_cnt), 32'(got.cnt));
        end
    endtask

    localparam logic [PC_W-1:0] Z = '0;

    initial begin
        drive(1, 0, 0,0,0,Z, 0,0,0,Z);
        tick("rst0", 0);
        tick("rst1", 1);
        chk("reset_pc", 32'(f_pc), 32'h0);
        chk("reset_cnt", 32'(redirect_cnt), 32'h0);

        drive(0, 0, 0,0,0,Z, 0,0,0,Z);
        tick("seq8", 1);  chk("pc8", 32'(f_pc), 32'd8);
        tick("seq16", 1); chk("pc16", 32'(f_pc), 32'd16);
        tick("seq24", 1); chk("pc24", 32'(f_pc), 32'd24);

        drive(0, 0, 0,0,0,Z, 1,0,1,15'h0104);
        chk("x1_flush_d", 32'(flush_d), 32'd1);
        chk("x1_flush_x1", 32'(flush_x1), 32'd0);
        tick("x1_redir", 1);
        chk("x1_pc", 32'(f_pc), 32'h0100);
        chk("x1_slot0", 32'(f_slot0_valid), 32'd0);
        chk("x1_cnt", 32'(redirect_cnt), 32'd1);

        drive(0, 0, 1,0,1,15'h0040, 1,1,0,15'h0200);
        chk("both_flush_x1", 32'(flush_x1), 32'd1);
        tick("both_redir", 1);
        chk("both_pc", 32'(f_pc), 32'h0040);
        chk("both_cnt", 32'(redirect_cnt), 32'd2);

        drive(0, 1, 1,1,0,15'h0080, 0,0,0,Z);
        for (int i = 0; i < 4; i++) begin
            chk("stall_no_flush", 32'(flush_d), 32'd0);
            tick("stall_hold", 1);
            chk("stall_pc_frozen", 32'(f_pc), 32'h0040);
        end
        drive(0, 0, 1,1,0,15'h0080, 0,0,0,Z);
        chk("release_flush_d", 32'(flush_d), 32'd1);
        tick("release", 1);
        chk("release_pc", 32'(f_pc), 32'h0080);
        chk("release_cnt", 32'(redirect_cnt), 32'd3);

        drive(0, 1, 0,0,0,Z, 0,0,0,Z);
        tick("hold0", 1);
        tick("hold1", 1);
        drive(0, 1, 0,0,0,Z, 1,0,1,15'h0204);
        tick("hold_capture", 1);
        drive(0, 1, 0,0,0,Z, 1,1,0,15'h0300);
        tick("hold_ignore", 1);
        drive(0, 0, 0,0,0,Z, 1,1,0,15'h0300);
        tick("hold_release", 1);
        chk("hold_release_pc", 32'(f_pc), 32'h0200);
        chk("hold_release_s0", 32'(f_slot0_valid), 32'd0);

        drive(0, 1, 1,1,0,15'h0500, 0,0,0,Z);
        tick("hr_capture", 1);
        drive(1, 1, 1,1,0,15'h0500, 0,0,0,Z);
        tick("hr_reset", 1);
        chk("hr_reset_pc", 32'(f_pc), 32'(RESET_PC));
        drive(0, 0, 0,0,0,Z, 0,0,0,Z);
        tick("post_reset", 1);
        chk("no_late_redir", 32'(f_pc), 32'h0008);

        drive(0, 0, 1,1,0,15'h7FF8, 0,0,0,Z);
        tick("to_top", 1);
        chk("top_pc", 32'(f_pc), 32'h7FF8);
        drive(0, 0, 0,0,0,Z, 0,0,0,Z);
        tick("wrap", 1);
        chk("wrap_pc", 32'(f_pc), 32'h0000);

        drive(0, 0, 1,0,1,15'h0010, 0,0,0,Z);
        for (int i = 0; i < 70000 && m_cnt != 16'hFFFF; i++) tick("sat_fill", 0);
        chk("sat_reached", 32'(redirect_cnt), 32'hFFFF);
        tick("sat_hold", 1);
        chk("sat_stays", 32'(redirect_cnt), 32'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_redirect.md
# fetch_redirect

Fetch-side PC generator for the dual-issue pipeline. It consumes the branch and jump resolution from both execute lanes and drives the next fetch address pair to instruction memory. It also produces the flush controls that kill wrong-path instructions, and holds a resolved redirect across pipeline stalls. The execute lanes produce the redirect; this block receives it.

## Interface
Parameters:
- `PC_W`, 15: PC width in bits, byte address.
- `RESET_PC`, 15'h0000: fetch address after reset. Must be 8-byte aligned.
- `CNT_W`, 16: width of the redirect performance counter.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `x0_valid` in 1: lane 0 holds a valid instruction. Lane 0 is the older lane.
- `x0_is_jump` in 1: lane 0 instruction is jal or jalr.
- `x0_br_taken` in 1: lane 0 branch resolved taken.
- `x0_t_pc` in `PC_W`: lane 0 target PC.
- `x1_valid`, `x1_is_jump`, `x1_br_taken`, `x1_t_pc`: the same four signals for lane 1, the younger lane.
- `stall` in 1: pipeline frozen. This is the OR of both lanes' `busy`, `w_miss` and `wait_load`.
- `f_pc` out `PC_W`: fetch address. Always 8-byte aligned.
- `f_slot0_valid` out 1: the instruction at `f_pc` is on the correct path.
- `f_slot1_valid` out 1: the instruction at `f_pc+4` is on the correct path.
- `flush_d` out 1: kill both instructions in decode.
- `flush_x1` out 1: kill execute lane 1.
- `redirect_cnt` out `CNT_W`: number of applied redirects. Saturates at its maximum value.

## Operation
- Lane redirect condition: `xN_redir = xN_valid & (xN_is_jump | xN_br_taken)`.
- Lane 0 has priority. Lane 1 counts only when `!x0_redir`.
- Selected target: `tgt = x0_redir ? x0_t_pc : x1_t_pc`.
- State machine has three states: RUN, HOLD and HOLD_REDIR.
- RUN, with `!stall` and a redirect:
  - `f_pc <= {tgt[14:3],3'b000}`, `f_slot0_valid <= !tgt[2]`, `f_slot1_valid <= 1`.
  - Increment `redirect_cnt`.
  - Stay in RUN.
- RUN, with `!stall` and no redirect: `f_pc <= f_pc + 8`, both slot valids `<= 1`.
- RUN, with `stall`:
  - Hold `f_pc` and both slot valids.
  - If a redirect is present, capture `tgt` into `pend_tgt` and go to HOLD_REDIR. Otherwise go to HOLD.
- HOLD:
  - Behaves like RUN in every respect, except that it is entered only from a stall.
  - A redirect arriving while still stalled is captured and moves to HOLD_REDIR.
  - When `stall` drops, the cycle is processed exactly like RUN with `!stall`, and the state moves to RUN.
- HOLD_REDIR:
  - Further redirect inputs are ignored, because the captured redirect is the oldest. X is frozen and presents the same instruction.
  - When `stall` drops: apply `pend_tgt` using the RUN-redirect rule, increment the counter, go to RUN.
- Flush outputs are combinational.
  - `flush_d = (!stall & (x0_redir | x1_redir)) | (state==HOLD_REDIR & !stall)`.
  - `flush_x1 = !stall & x0_redir`. This holds in all states, and in HOLD_REDIR it refers to the frozen lane 0.
- Width rules:
  - `f_pc + 8` wraps modulo 2^15, with no overflow flag.
  - Target bits [1:0] are ignored. Misalignment is not checked.
- Reset values: `f_pc=RESET_PC`, `f_slot0_valid=1`, `f_slot1_valid=1`, `redirect_cnt=0`, state RUN, `pend_tgt=0`.
- Reset has priority over all events, including mid-HOLD_REDIR. Any pending redirect is discarded.

## Timing
- Redirect latency:
  - Redirect in cycle N with `!stall` gives the new `f_pc` in cycle N+1.
  - `flush_d` and `flush_x1` are high in cycle N.
- Stalled redirect:
  - Captured in cycle N.
  - `stall` falls in cycle M. The flush fires in cycle M and the new `f_pc` appears in M+1.
- Simultaneous `x0_redir` and `x1_redir`: lane 0 wins, `flush_x1=1`, and the count increments by 1.
- Counter at all-ones stays at all-ones.
- `reset` asserted in cycle N: outputs take their reset values in cycle N+1.

## Structure
- Shared package `fetch_pkg`: `PC_W`, state encoding `FR_RUN`/`FR_HOLD`/`FR_HOLD_REDIR`, and the `FETCH_STRIDE=8` constant.
- Sub-module `redir_arb`: the combinational lane-priority arbiter, producing `redir` and `tgt`.
- Everything else is a single sequential process plus the flush logic.

## Test plan
- Reset, then 3 cycles with no stall and no redirect: `f_pc` goes 0, 8, 16, 24 and both slot valids stay 1.
- `x1_valid=1`, `x1_br_taken=1`, `x1_t_pc=15'h0104`, no stall: `flush_d=1`, `flush_x1=0`, next `f_pc=15'h0100`, `f_slot0_valid=0`, `redirect_cnt=1`.
- Both lanes redirect, with x0 to 15'h0040 and x1 to 15'h0200: next `f_pc=15'h0040`, `flush_x1=1`, count increments by 1.
- `stall=1` with `x0_is_jump` to 15'h0080, held 4 cycles, then `stall=0`:
  - `f_pc` is frozen and no flush occurs during the stall.
  - Flush fires on the release cycle and `f_pc=15'h0080` the cycle after.
- In HOLD_REDIR, assert `reset`: next cycle `f_pc=RESET_PC`, state RUN, and no late redirect is applied.
- `f_pc=15'h7FF8` with no redirect wraps to 15'h0000. A counter preloaded at 16'hFFFF stays at 16'hFFFF after a further redirect.
